// File: rtl/softex_lane_scatter.sv
// Scatters one wide streamer beat across NUM_LANES lane FIFOs (strided or contiguous),
// with a run-time active-lane count, element-count tail masking and a drain/done handshake.
module softex_lane_scatter #(
    parameter int unsigned NUM_LANES      = 4,
    parameter int unsigned ELEM_WIDTH     = 16,
    parameter int unsigned ELEMS_PER_LANE = 4,
    parameter int unsigned FIFO_DEPTH     = 2,
    parameter int unsigned LEN_WIDTH      = 16,
    localparam int unsigned LANE_WIDTH    = ELEMS_PER_LANE * ELEM_WIDTH,
    localparam int unsigned DATA_WIDTH    = NUM_LANES * LANE_WIDTH,
    localparam int unsigned NA_W          = $clog2(NUM_LANES + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                clear_i,
    input  logic                                start_i,
    input  logic                                mode_i,
    input  logic [NA_W-1:0]                     n_active_i,
    input  logic [LEN_WIDTH-1:0]                len_i,
    output logic                                busy_o,
    output logic                                done_o,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    input  logic [DATA_WIDTH-1:0]               in_data_i,
    output logic [NUM_LANES-1:0]                lane_valid_o,
    input  logic [NUM_LANES-1:0]                lane_ready_i,
    output logic [NUM_LANES*LANE_WIDTH-1:0]     lane_data_o,
    output logic [NUM_LANES*ELEMS_PER_LANE-1:0] lane_strb_o,
    output logic [NUM_LANES-1:0]                lane_last_o
);

    localparam int unsigned NUM_ELEMS = NUM_LANES * ELEMS_PER_LANE;
    localparam int unsigned IDX_W     = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
    localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic [LANE_WIDTH-1:0]     data;
        logic [ELEMS_PER_LANE-1:0] strb;
        logic                      last;
    } entry_t;

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [NA_W-1:0]       n_q, n_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  in_ready_q, in_ready_d;
    logic [NUM_LANES-1:0]  valid_q, valid_d;

    logic [PTR_W-1:0]      rd_q  [NUM_LANES];
    logic [PTR_W-1:0]      rd_d  [NUM_LANES];
    logic [PTR_W-1:0]      wr_q  [NUM_LANES];
    logic [PTR_W-1:0]      wr_d  [NUM_LANES];
    logic [CNT_W-1:0]      cnt_q [NUM_LANES];
    logic [CNT_W-1:0]      cnt_d [NUM_LANES];
    entry_t                mem_q [NUM_LANES][FIFO_DEPTH];
    entry_t                mem_d [NUM_LANES][FIFO_DEPTH];

    logic [NA_W-1:0]       n_in_eff;
    logic [LEN_WIDTH-1:0]  beat_len;
    logic                  last_beat;
    logic                  accept;
    logic                  all_empty;
    logic [NUM_LANES-1:0]  active;
    logic [NUM_LANES-1:0]  push;
    logic [NUM_LANES-1:0]  pop;
    logic [IDX_W-1:0]      idx_tab    [NUM_LANES][ELEMS_PER_LANE];
    entry_t                beat_entry [NUM_LANES];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Zero or out-of-range lane counts fall back to all lanes.
    assign n_in_eff  = (n_active_i == '0 || n_active_i > NA_W'(NUM_LANES)) ?
                       NA_W'(NUM_LANES) : n_active_i;
    assign beat_len  = LEN_WIDTH'(32'(n_q) * ELEMS_PER_LANE);
    assign last_beat = (rem_q <= beat_len);
    assign accept    = in_valid_i & in_ready_q;

    always_comb begin
        active    = '0;
        all_empty = 1'b1;
        for (int l = 0; l < NUM_LANES; l++) begin
            active[l] = (NA_W'(l) < n_q);
            push[l]   = accept & active[l];
            pop[l]    = valid_q[l] & lane_ready_i[l];
            if (cnt_q[l] != '0) begin
                all_empty = 1'b0;
            end
        end
    end

    // Beat-local element index feeding each lane slot.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int s = 0; s < ELEMS_PER_LANE; s++) begin
                if (mode_q) begin
                    idx_tab[l][s] = IDX_W'(l * ELEMS_PER_LANE + s);
                end else begin
                    idx_tab[l][s] = IDX_W'(s * int'(n_q) + l);
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            beat_entry[l]      = '0;
            beat_entry[l].last = last_beat;
            for (int s = 0; s < ELEMS_PER_LANE; s++) begin
                beat_entry[l].data[s*ELEM_WIDTH +: ELEM_WIDTH] =
                    in_data_i[32'(idx_tab[l][s]) * ELEM_WIDTH +: ELEM_WIDTH];
                beat_entry[l].strb[s] = (LEN_WIDTH'(idx_tab[l][s]) < rem_q);
            end
        end
    end

    // Per-lane FIFO bookkeeping; each lane pops independently.
    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (push[l]) begin
                mem_d[l][wr_q[l]] = beat_entry[l];
                wr_d[l]           = ptr_inc(wr_q[l]);
            end
            if (pop[l]) begin
                rd_d[l] = ptr_inc(rd_q[l]);
            end
            case ({push[l], pop[l]})
                2'b10:   cnt_d[l] = cnt_q[l] + CNT_W'(1);
                2'b01:   cnt_d[l] = cnt_q[l] - CNT_W'(1);
                default: cnt_d[l] = cnt_q[l];
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        n_d     = n_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        state_d = ST_RUN;
                        mode_d  = mode_i;
                        n_d     = n_in_eff;
                        rem_d   = len_i;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (last_beat) begin
                        state_d = ST_DRAIN;
                    end else begin
                        rem_d = rem_q - beat_len;
                    end
                end
            end
            ST_DRAIN: begin
                if (all_empty) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Ready is precomputed from next-cycle occupancy so it carries no path from lane_ready_i.
        busy_d     = (state_d != ST_IDLE);
        in_ready_d = (state_d == ST_RUN);
        for (int l = 0; l < NUM_LANES; l++) begin
            valid_d[l] = (cnt_d[l] != '0);
            if (NA_W'(l) < n_d && cnt_d[l] == CNT_W'(FIFO_DEPTH)) begin
                in_ready_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            n_q        <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
            valid_q    <= '0;
            rd_q       <= '{default: '0};
            wr_q       <= '{default: '0};
            cnt_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            n_q        <= n_d;
            rem_q      <= rem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
            valid_q    <= valid_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Storage needs no reset: heads are only exposed while the lane is valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_comb begin
        lane_data_o = '0;
        lane_strb_o = '0;
        lane_last_o = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (valid_q[l]) begin
                lane_data_o[l*LANE_WIDTH +: LANE_WIDTH]         = mem_q[l][rd_q[l]].data;
                lane_strb_o[l*ELEMS_PER_LANE +: ELEMS_PER_LANE] = mem_q[l][rd_q[l]].strb;
                lane_last_o[l]                                  = mem_q[l][rd_q[l]].last;
            end
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign in_ready_o   = in_ready_q;
    assign lane_valid_o = valid_q;

endmodule
